full_top: RTL and testbench

FULL_TOP -- requirements
Module: full_top

---
 rtl/full_top_pkg.sv | 78 +++++++
 rtl/full_top_clk_divider.sv | 38 +++
 rtl/full_top.sv | 101 ++++++++++
 tb/tb_full_top.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/full_top_pkg.sv
// Shared definitions for the tug-of-war game: state encoding, LED patterns
// and the one-step rope movement rules.
package full_top_pkg;

    typedef enum logic [3:0] {
        ST_BLANK,
        ST_L3,
        ST_L2,
        ST_L1,
        ST_N,
        ST_R1,
        ST_R2,
        ST_R3,
        ST_LWIN,
        ST_RWIN
    } state_t;

    localparam logic [6:0] LEDS_BLANK = 7'b0000000;
    localparam logic [6:0] LEDS_L3    = 7'b1000000;
    localparam logic [6:0] LEDS_L2    = 7'b0100000;
    localparam logic [6:0] LEDS_L1    = 7'b0010000;
    localparam logic [6:0] LEDS_N     = 7'b0001000;
    localparam logic [6:0] LEDS_R1    = 7'b0000100;
    localparam logic [6:0] LEDS_R2    = 7'b0000010;
    localparam logic [6:0] LEDS_R3    = 7'b0000001;
    localparam logic [6:0] LEDS_LWIN  = 7'b1110000;
    localparam logic [6:0] LEDS_RWIN  = 7'b0000111;

    function automatic logic [6:0] leds_of(input state_t s);
        logic [6:0] v;
        case (s)
            ST_L3:   v = LEDS_L3;
            ST_L2:   v = LEDS_L2;
            ST_L1:   v = LEDS_L1;
            ST_N:    v = LEDS_N;
            ST_R1:   v = LEDS_R1;
            ST_R2:   v = LEDS_R2;
            ST_R3:   v = LEDS_R3;
            ST_LWIN: v = LEDS_LWIN;
            ST_RWIN: v = LEDS_RWIN;
            default: v = LEDS_BLANK;
        endcase
        return v;
    endfunction

    // R3 jumps back to R1: the losing (left) player gets a two-step boost.
    function automatic state_t step_left(input state_t s);
        state_t v;
        case (s)
            ST_R3:   v = ST_R1;
            ST_R2:   v = ST_R1;
            ST_R1:   v = ST_N;
            ST_N:    v = ST_L1;
            ST_L1:   v = ST_L2;
            ST_L2:   v = ST_L3;
            ST_L3:   v = ST_LWIN;
            default: v = s;
        endcase
        return v;
    endfunction

    // Mirror of step_left; L3 jumps back to L1.
    function automatic state_t step_right(input state_t s);
        state_t v;
        case (s)
            ST_L3:   v = ST_L1;
            ST_L2:   v = ST_L1;
            ST_L1:   v = ST_N;
            ST_N:    v = ST_R1;
            ST_R1:   v = ST_R2;
            ST_R2:   v = ST_R3;
            ST_R3:   v = ST_RWIN;
            default: v = s;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/full_top_clk_divider.sv
// Game clock generator: a DIV_W-bit down-counter that toggles the divided
// clock each time it passes zero, plus a one-cycle tick on its rising edge.
module clk_divider #(
    parameter int DIV_W = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_clock_div,
    output logic o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_div;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == '0);

    // Free-running counter; the tick is registered so it is high in the same
    // cycle that o_clock_div is first seen high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt - DIV_W'(1);
            r_tick <= w_wrap & ~r_div;
            if (w_wrap) begin
                r_div <= ~r_div;
            end
        end
    end

    assign o_clock_div = r_div;
    assign o_tick      = r_tick;

endmodule

// File: rtl/full_top.sv
// Tug-of-war game controller.
//
// state  | meaning
// BLANK  | after reset, display dark until the first game tick
// L3..L1 | rope pulled 3..1 steps toward the left player
// N      | rope centred
// R1..R3 | rope pulled 1..3 steps toward the right player
// LWIN   | left player won, terminal until reset
// RWIN   | right player won, terminal until reset
module full_top
    import full_top_pkg::*;
#(
    parameter int DIV_W = 1
) (
    input  logic       CLK_I,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    output logic       clock_div,
    output logic [6:0] leds_out
);

    logic       w_tick;
    logic [1:0] r_pbl_sync;
    logic [1:0] r_pbr_sync;
    logic       r_pbl_low;
    logic       r_pbr_low;
    logic       w_press_l;
    logic       w_press_r;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_leds;

    clk_divider #(.DIV_W(DIV_W)) u_clk_divider (
        .i_clk       (CLK_I),
        .i_rst_n     (rst),
        .o_clock_div (clock_div),
        .o_tick      (w_tick)
    );

    // Two-flop synchronizers for the asynchronous push buttons.
    always_ff @(posedge CLK_I or negedge rst) begin
        if (!rst) begin
            r_pbl_sync <= 2'b00;
            r_pbr_sync <= 2'b00;
        end else begin
            r_pbl_sync <= {r_pbl_sync[0], pbl};
            r_pbr_sync <= {r_pbr_sync[0], pbr};
        end
    end

    // Remember whether each button was low at the previous tick. The flags
    // stay cleared through BLANK, so a button held across reset release must
    // be seen low on a tick before it can count as a press.
    always_ff @(posedge CLK_I or negedge rst) begin
        if (!rst) begin
            r_pbl_low <= 1'b0;
            r_pbr_low <= 1'b0;
        end else if (w_tick && (r_state != ST_BLANK)) begin
            r_pbl_low <= ~r_pbl_sync[1];
            r_pbr_low <= ~r_pbr_sync[1];
        end
    end

    assign w_press_l = w_tick & r_pbl_sync[1] & r_pbl_low;
    assign w_press_r = w_tick & r_pbr_sync[1] & r_pbr_low;

    // State register; the LED pattern is registered from the next state so
    // it follows the tick by exactly one cycle.
    always_ff @(posedge CLK_I or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BLANK;
            r_leds  <= LEDS_BLANK;
        end else begin
            r_state <= w_state_nxt;
            r_leds  <= leds_of(w_state_nxt);
        end
    end

    // Next-state logic: single-sided presses move the rope; a tie does nothing.
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                ST_BLANK: w_state_nxt = ST_N;
                ST_LWIN,
                ST_RWIN:  w_state_nxt = r_state;
                default: begin
                    if (w_press_l && !w_press_r) begin
                        w_state_nxt = step_left(r_state);
                    end else if (w_press_r && !w_press_l) begin
                        w_state_nxt = step_right(r_state);
                    end
                end
            endcase
        end
    end

    assign leds_out = r_leds;

endmodule

// File: tb/tb_full_top.sv
module tb_full_top;

    localparam int DIV_W = 1;
    localparam int PER   = 1 << (DIV_W + 1);
    localparam int HOLD  = 3 * PER;

    logic       CLK_I = 1'b0;
    logic       rst   = 1'b1;
    logic       pbl   = 1'b0;
    logic       pbr   = 1'b0;
    logic       clock_div;
    logic [6:0] leds_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: rope position -3 (far left) .. +3 (far right)
    // and a game mode: 0 blank, 1 playing, 2 left won, 3 right won.
    int m_pos  = 0;
    int m_mode = 0;

    full_top #(.DIV_W(DIV_W)) dut (
        .CLK_I     (CLK_I),
        .rst       (rst),
        .pbl       (pbl),
        .pbr       (pbr),
        .clock_div (clock_div),
        .leds_out  (leds_out)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] m_leds();
        logic [6:0] v;
        case (m_mode)
            0:       v = 7'b0000000;
            2:       v = 7'b1110000;
            3:       v = 7'b0000111;
            default: v = 7'b0000001 << (3 - m_pos);
        endcase
        return v;
    endfunction

    function automatic void m_move(input bit l, input bit r);
        if (m_mode != 1 || l == r) return;
        if (l) begin
            if (m_pos == 3)       m_pos = 1;
            else if (m_pos == -3) m_mode = 2;
            else                  m_pos = m_pos - 1;
        end else begin
            if (m_pos == -3)      m_pos = -1;
            else if (m_pos == 3)  m_mode = 3;
            else                  m_pos = m_pos + 1;
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK_I);
            #1;
        end
    endtask

    // Press (l, r) for several game periods, release for as long, then compare.
    task automatic act(input bit l, input bit r, input string tag);
        pbl = l;
        pbr = r;
        cyc(HOLD);
        pbl = 1'b0;
        pbr = 1'b0;
        cyc(HOLD);
        m_move(l, r);
        chk(tag, leds_out, m_leds());
    endtask

    // Reset asserted between edges: the display must clear with no clock edge.
    task automatic do_reset(input int n);
        rst = 1'b0;
        #1;
        m_mode = 0;
        chk("rst_async", leds_out, m_leds());
        cyc(n);
        chk("rst_leds", leds_out, 7'b0000000);
        chk("rst_div", {6'b0, clock_div}, 7'b0000000);
        rst = 1'b1;
        cyc(PER + 2);
        m_mode = 1;
        m_pos  = 0;
        chk("rst_to_n", leds_out, m_leds());
    endtask

    initial begin
        int r;
        #2 rst = 1'b0;
        @(posedge CLK_I);
        #1;

        // Power-on reset, then divider phase and BLANK -> N timing.
        for (int i = 0; i < 100; i++) begin
            if (i % 25 == 0) chk("por_leds", leds_out, 7'b0000000);
            cyc(1);
        end
        chk("por_div", {6'b0, clock_div}, 7'b0000000);
        rst = 1'b1;
        for (int n = 1; n <= 4 * PER; n++) begin
            cyc(1);
            chk("div_phase", {6'b0, clock_div}, (((n - 1) / (PER / 2)) % 2 == 0) ? 7'd1 : 7'd0);
            if (n == 1) chk("blank_hold", leds_out, 7'b0000000);
            if (n == PER + 2) begin
                m_mode = 1;
                m_pos  = 0;
                chk("first_n", leds_out, m_leds());
            end
        end

        // Rightward steps, then favour-the-loser from R3.
        act(0, 1, "r_step1");
        act(0, 1, "r_step2");
        act(0, 1, "r_step3");
        act(1, 0, "favor_l");

        // Left all the way to LWIN, then presses are ignored.
        for (int i = 0; i < 5; i++) act(1, 0, "l_walk");
        act(1, 0, "lwin_hold_l");
        act(0, 1, "lwin_hold_r");
        act(1, 1, "lwin_hold_b");

        // Reset out of LWIN and play a few moves.
        do_reset(7);
        act(0, 1, "post_rst_r");
        act(1, 0, "post_rst_l1");
        act(1, 0, "post_rst_l2");

        // A 50-cycle hold counts once.
        do_reset(3);
        pbr = 1'b1;
        cyc(50);
        pbr = 1'b0;
        cyc(HOLD);
        m_move(0, 1);
        chk("long_hold", leds_out, m_leds());

        // Tie does nothing; mirror walk to RWIN including favour from L3.
        do_reset(3);
        act(1, 1, "tie_n");
        act(1, 0, "ml1");
        act(1, 0, "ml2");
        act(1, 0, "ml3");
        act(0, 1, "favor_r");
        for (int i = 0; i < 5; i++) act(0, 1, "r_walk");
        act(0, 1, "rwin_hold_r");
        act(1, 0, "rwin_hold_l");

        // A button held across reset release is not a press until re-pressed.
        pbr = 1'b1;
        do_reset(4);
        cyc(2 * HOLD);
        chk("held_rst", leds_out, m_leds());
        pbr = 1'b0;
        cyc(HOLD);
        chk("held_rel", leds_out, m_leds());
        act(0, 1, "held_repress");

        // Random play against the model.
        do_reset(3);
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (m_mode >= 2 && $urandom_range(0, 1) == 1) do_reset(2);
            else if (r < 4)  act(1, 0, "rnd_l");
            else if (r < 8)  act(0, 1, "rnd_r");
            else if (r == 8) act(1, 1, "rnd_tie");
            else             act(0, 0, "rnd_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
